// File: rtl/clock_pkg.sv
// Shared field limits, widths and edit-FSM encoding for the clock time setter.
package clock_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2,
    S_SEC  = 2'd3
  } state_e;

  // Out-of-range values collapse to 0, so a corrupted field self-heals on the next step.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] vmax);
    return (v >= vmax) ? 6'd0 : v + 6'd1;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-FF synchronizer, stability debouncer and
// one-cycle press pulse on the debounced falling edge.
module key_debounce #(
  parameter int DB_CNT = 20000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);
  localparam int DBC = (DB_CNT < 1) ? 1 : DB_CNT;
  localparam int CW  = (DBC > 1) ? $clog2(DBC) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  // The level flips only after DBC consecutive cycles that disagree with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DBC - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;
endmodule

// File: rtl/time_setter.sv
// Two-key time editor: mode cycles hour/min/sec edit fields and commits with a
// load pulse, inc steps the active field. Optional hold-to-repeat: TIMESET_AUTOREPEAT_EN.
module time_setter
  import clock_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HZ    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              key_mode,
  input  logic              key_inc,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  output logic [HOUR_W-1:0] set_hour,
  output logic [MIN_W-1:0]  set_min,
  output logic [SEC_W-1:0]  set_sec,
  output logic              load,
  output logic              setting,
  output logic [2:0]        blink_mask
);
  localparam int DB_CNT = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int HALF   = CLK_FREQ / (2 * BLINK_HZ);
  localparam int HALF_C = (HALF < 2) ? 2 : HALF;
  localparam int BW     = $clog2(HALF_C);

  // Key 0 = mode, key 1 = inc.
  logic [1:0] w_keys;
  logic [1:0] w_level;
  logic [1:0] w_press;

  assign w_keys = {key_inc, key_mode};

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk     (clk),
      .rstn    (rstn),
      .i_key_n (w_keys[k]),
      .o_level (w_level[k]),
      .o_press (w_press[k])
    );
  end

  state_e            r_state;
  logic [HOUR_W-1:0] r_hour;
  logic [MIN_W-1:0]  r_min;
  logic [SEC_W-1:0]  r_sec;
  logic              r_load;
  logic              r_setting;
  logic [2:0]        r_mask;
  logic [BW-1:0]     r_bcnt;
  logic              r_phase;

  logic w_mode_evt;
  logic w_inc_evt;

  assign w_mode_evt = w_press[0];

`ifdef TIMESET_AUTOREPEAT_EN
  localparam int REP_DELAY  = CLK_FREQ / 2;
  localparam int REP_PERIOD = CLK_FREQ / 10;
  localparam int RW         = $clog2((REP_DELAY < 2) ? 2 : REP_DELAY);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_armed;
  logic          r_rep_pulse;
  logic          w_unused_mode_level;

  assign w_unused_mode_level = w_level[0];

  // First repeat after the hold delay, then one per repeat period while held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_pulse <= 1'b0;
    end else begin
      r_rep_pulse <= 1'b0;
      if (w_press[1] || w_level[1] || r_state == IDLE) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
      end else if (!r_rep_armed && r_rep_cnt == RW'(REP_DELAY - 1)) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b1;
        r_rep_pulse <= 1'b1;
      end else if (r_rep_armed && r_rep_cnt == RW'(REP_PERIOD - 1)) begin
        r_rep_cnt   <= '0;
        r_rep_pulse <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  assign w_inc_evt = w_press[1] | r_rep_pulse;
`else
  logic [1:0] w_unused_level;

  assign w_unused_level = w_level;
  assign w_inc_evt      = w_press[1];
`endif

  state_e            w_state_nx;
  logic [HOUR_W-1:0] w_hour_nx;
  logic [MIN_W-1:0]  w_min_nx;
  logic [SEC_W-1:0]  w_sec_nx;
  logic              w_load_nx;
  logic [BW-1:0]     w_bcnt_nx;
  logic              w_phase_nx;
  logic [2:0]        w_mask_nx;
  logic [5:0]        w_hour_inc;
  logic [5:0]        w_min_inc;
  logic [5:0]        w_sec_inc;
  logic              w_blink_rst;

  always_comb begin
    w_state_nx  = r_state;
    w_hour_nx   = r_hour;
    w_min_nx    = r_min;
    w_sec_nx    = r_sec;
    w_load_nx   = 1'b0;
    w_blink_rst = 1'b0;
    w_hour_inc  = inc_wrap({1'b0, r_hour}, {1'b0, HOUR_MAX});
    w_min_inc   = inc_wrap(r_min, MIN_MAX);
    w_sec_inc   = inc_wrap(r_sec, SEC_MAX);

    // Mode outranks inc: an inc landing with a mode press is dropped.
    case (r_state)
      IDLE: begin
        if (w_mode_evt) begin
          w_state_nx  = S_HOUR;
          w_hour_nx   = cur_hour;
          w_min_nx    = cur_min;
          w_sec_nx    = cur_sec;
          w_blink_rst = 1'b1;
        end
      end
      S_HOUR: begin
        if (w_mode_evt) begin
          w_state_nx = S_MIN;
        end else if (w_inc_evt) begin
          w_hour_nx   = w_hour_inc[HOUR_W-1:0];
          w_blink_rst = 1'b1;
        end
      end
      S_MIN: begin
        if (w_mode_evt) begin
          w_state_nx = S_SEC;
        end else if (w_inc_evt) begin
          w_min_nx    = w_min_inc;
          w_blink_rst = 1'b1;
        end
      end
      S_SEC: begin
        if (w_mode_evt) begin
          w_state_nx = IDLE;
          w_load_nx  = 1'b1;
        end else if (w_inc_evt) begin
          w_sec_nx    = w_sec_inc;
          w_blink_rst = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    if (r_state == IDLE && !w_blink_rst) begin
      w_bcnt_nx  = '0;
      w_phase_nx = 1'b0;
    end else if (w_blink_rst) begin
      w_bcnt_nx  = '0;
      w_phase_nx = 1'b0;
    end else if (r_bcnt == BW'(HALF_C - 1)) begin
      w_bcnt_nx  = '0;
      w_phase_nx = ~r_phase;
    end else begin
      w_bcnt_nx  = r_bcnt + 1'b1;
      w_phase_nx = r_phase;
    end

    case (w_state_nx)
      S_HOUR:  w_mask_nx = {w_phase_nx, 2'b00};
      S_MIN:   w_mask_nx = {1'b0, w_phase_nx, 1'b0};
      S_SEC:   w_mask_nx = {2'b00, w_phase_nx};
      default: w_mask_nx = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_hour    <= '0;
      r_min     <= '0;
      r_sec     <= '0;
      r_load    <= 1'b0;
      r_setting <= 1'b0;
      r_mask    <= 3'b000;
      r_bcnt    <= '0;
      r_phase   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_hour    <= w_hour_nx;
      r_min     <= w_min_nx;
      r_sec     <= w_sec_nx;
      r_load    <= w_load_nx;
      r_setting <= (w_state_nx != IDLE);
      r_mask    <= w_mask_nx;
      r_bcnt    <= w_bcnt_nx;
      r_phase   <= w_phase_nx;
    end
  end

  assign set_hour   = r_hour;
  assign set_min    = r_min;
  assign set_sec    = r_sec;
  assign load       = r_load;
  assign setting    = r_setting;
  assign blink_mask = r_mask;
endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter at CLK_FREQ=1000, DEBOUNCE_MS=2, BLINK_HZ=2
// (debounce 2 cycles, blink half-period 250 cycles).
module tb_time_setter;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_inc = 1'b1;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       load;
  logic       setting;
  logic [2:0] blink_mask;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_load = 0;
  logic [16:0] load_val = '0;

  always #5 clk = ~clk;

  time_setter #(.CLK_FREQ(1000), .DEBOUNCE_MS(2), .BLINK_HZ(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_mode   (key_mode),
    .key_inc    (key_inc),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .load       (load),
    .setting    (setting),
    .blink_mask (blink_mask)
  );

  always @(negedge clk) begin
    if (load) begin
      n_load   = n_load + 1;
      load_val = {set_hour, set_min, set_sec};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic m, input logic i);
    @(negedge clk);
    if (m) key_mode = 1'b0;
    if (i) key_inc = 1'b0;
    repeat (6) @(negedge clk);
    key_mode = 1'b1;
    key_inc  = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Edit field is identified by which mask bit lights up during the blink phase.
  task automatic wait_field(input string tag, input logic [2:0] exp);
    int n = 0;
    while (blink_mask == 3'b000 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, blink_mask, exp);
  endtask

  task automatic run_len(input logic [2:0] val, output int n);
    n = 0;
    while (blink_mask == val && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int bad;

    repeat (3) @(negedge clk);
    chk("rst_setting", setting, 0);
    chk("rst_mask", blink_mask, 0);
    chk("rst_set", {set_hour, set_min, set_sec}, 0);
    chk("rst_load", load, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // One-cycle glitch must not register.
    key_mode = 1'b0;
    @(negedge clk);
    key_mode = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_setting", setting, 0);
    chk("glitch_mask", blink_mask, 0);

    press(1'b0, 1'b1);
    chk("idle_inc_ignored", {set_hour, set_min, set_sec}, 0);

    // Full edit 12:34:56 -> 15:35:56.
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    press(1'b1, 1'b0);
    chk("edit_setting", setting, 1);
    chk("edit_capture", {set_hour, set_min, set_sec}, {5'd12, 6'd34, 6'd56});
    repeat (3) press(1'b0, 1'b1);
    chk("edit_hour_inc3", set_hour, 15);
    press(1'b1, 1'b0);
    wait_field("edit_in_min", 3'b010);
    press(1'b0, 1'b1);
    chk("edit_min_inc", set_min, 35);
    press(1'b1, 1'b0);
    wait_field("edit_in_sec", 3'b001);
    press(1'b1, 1'b0);
    chk("edit_load_once", n_load, 1);
    chk("edit_load_val", load_val, {5'd15, 6'd35, 6'd56});
    chk("edit_idle_setting", setting, 0);
    chk("edit_idle_mask", blink_mask, 0);
    cur_hour = 5'd1; cur_min = 6'd1; cur_sec = 6'd1;
    repeat (5) @(negedge clk);
    chk("idle_hold", {set_hour, set_min, set_sec}, {5'd15, 6'd35, 6'd56});

    // Wrap at each field maximum.
    cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd59;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("wrap_hour", set_hour, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    chk("wrap_load_cnt", n_load, 2);
    chk("wrap_load_val", load_val, 0);

    // Simultaneous mode+inc in S_MIN: mode wins.
    cur_hour = 5'd5; cur_min = 6'd10; cur_sec = 6'd20;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    chk("coll_min_kept", set_min, 10);
    wait_field("coll_in_sec", 3'b001);
    press(1'b1, 1'b0);
    chk("coll_load_cnt", n_load, 3);

    // Reset mid-edit abandons without load.
    cur_hour = 5'd7; cur_min = 6'd8; cur_sec = 6'd9;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("rstmid_min", set_min, 10);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rstmid_setting", setting, 0);
    chk("rstmid_mask", blink_mask, 0);
    chk("rstmid_set", {set_hour, set_min, set_sec}, 0);
    chk("rstmid_load", load, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_no_load", n_load, 3);
    cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
    press(1'b1, 1'b0);
    chk("rstmid_recapture", {set_hour, set_min, set_sec}, {5'd1, 6'd2, 6'd3});
    chk("rstmid_setting2", setting, 1);

    // Blink timing in S_HOUR.
    wait_field("blink_on", 3'b100);
    run_len(3'b100, n);
    chk("blink_high_len", n, 250);
    run_len(3'b000, n);
    chk("blink_low_len", n, 250);
    chk("blink_on_again", blink_mask, 3'b100);
    press(1'b0, 1'b1);
    chk("blink_inc_forces_off", blink_mask, 0);
    chk("blink_inc_hour", set_hour, 2);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (blink_mask != 3'b000) bad++;
    end
    chk("blink_restart_hold", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, giving the clk frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, giving the key stable time in ms; DB_CNT = CLK_FREQ/1000*DEBOUNCE_MS cycles.
REQ-003 SHALL have parameter BLINK_HZ, default 2, giving the blink rate; half-period = CLK_FREQ/(2*BLINK_HZ) cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port key_mode, input, 1 bit: raw mode key, active-low, asynchronous to clk.
REQ-007 SHALL have port key_inc, input, 1 bit: raw increment key, active-low, asynchronous to clk.
REQ-008 SHALL have ports cur_hour (5 bits), cur_min (6 bits) and cur_sec (6 bits), inputs: the running time from the time counter.
REQ-009 SHALL have ports set_hour (5 bits), set_min (6 bits) and set_sec (6 bits), outputs: the edited time and load data.
REQ-010 SHALL have port load, output, 1 bit: one-cycle pulse that commits set_* into the time counter.
REQ-011 SHALL have port setting, output, 1 bit: high while in any edit state.
REQ-012 SHALL have port blink_mask, output, 3 bits: {hour, min, sec}; 1 blanks that display field.

Function
REQ-013 Each key SHALL pass through a 2-FF synchronizer followed by a debouncer: the debounced level changes only after the synchronized level is stable for DB_CNT consecutive cycles.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced high-to-low transition; release SHALL generate no event.
REQ-015 The FSM SHALL have states IDLE, S_HOUR, S_MIN and S_SEC; the state changes on the edge after the press pulse.
REQ-016 A mode press in IDLE SHALL copy cur_* into the shadow registers (set_*) and go to S_HOUR.
REQ-017 Mode presses SHALL advance the FSM S_HOUR -> S_MIN -> S_SEC.
REQ-018 A mode press in S_SEC SHALL go to IDLE and assert load for exactly 1 cycle on that edge, with set_* holding the edited values.
REQ-019 An inc press in S_HOUR SHALL step set_hour +1, wrapping 23 -> 0; any value >= 23 SHALL go to 0.
REQ-020 An inc press in S_MIN SHALL step set_min with wrap 59 -> 0, and in S_SEC SHALL step set_sec with wrap 59 -> 0; any value >= 59 SHALL go to 0.
REQ-021 An inc press in IDLE SHALL be ignored.
REQ-022 When mode and inc press pulses coincide, mode SHALL win and the inc SHALL be dropped.
REQ-023 setting SHALL be 1 in S_HOUR, S_MIN and S_SEC, and 0 in IDLE.
REQ-024 A blink phase SHALL toggle every half-period; the counter SHALL clear on entry to S_HOUR, with phase starting at 0.
REQ-025 blink_mask SHALL be {phase,0,0} in S_HOUR, {0,phase,0} in S_MIN, {0,0,phase} in S_SEC, and 000 in IDLE.
REQ-026 An inc press SHALL force phase to 0 (field visible) and restart the half-period count.
REQ-027 set_* SHALL hold their value in IDLE; load SHALL never assert outside the S_SEC -> IDLE transition.

Reset
REQ-028 On rstn low: state = IDLE, set_* = 0, load = 0, setting = 0, blink_mask = 000, debounced levels = 1 (released), all counters = 0.
REQ-029 Reset asserted mid-edit SHALL abandon the edit without asserting load.

Configuration
REQ-030 With TIMESET_AUTOREPEAT_EN defined, holding inc in an edit state for 500 ms SHALL generate repeat increments every 100 ms until release, each obeying the wrap rules.
REQ-031 Without TIMESET_AUTOREPEAT_EN, exactly one increment SHALL occur per press, and no repeat counter logic SHALL be present.

Structure
REQ-032 Package clock_pkg SHALL hold HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59, the field widths (5/6/6) and the FSM state encoding.
REQ-033 Sub-module key_debounce (synchronizer, debouncer and press pulse) SHALL be instantiated once per key.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=2, BLINK_HZ=2)
REQ-034 Glitch: key_mode low for 1 cycle -> no event, state stays IDLE, setting=0.
REQ-035 Full edit: cur=12:34:56; mode; inc x3; mode; inc x1; mode; mode -> load pulses once, set=15:35:56, state IDLE.
REQ-036 Wrap: start with cur_hour=23, cur_min=59, cur_sec=59; one inc in each field -> set=00:00:00 at load.
REQ-037 Collision: mode and inc pulses in the same cycle while in S_MIN -> state S_SEC, set_min unchanged.
REQ-038 Reset in S_MIN after 2 incs -> outputs at reset values, load never seen, next mode press recaptures cur_*.
REQ-039 Blink: in S_HOUR, blink_mask toggles between 100 and 000 every 250 cycles; an inc press forces 000.
